// File: rtl/cpt_capture8_if.sv
// Capture-path bus for cpt_capture8: rippling counter input, trigger, match controls and
// the valid/ready drain side of the capture FIFO.
interface cpt_capture8_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         count_in;
  logic                     trigger;
  logic [WIDTH-1:0]         match_val;
  logic                     match_en;
  logic                     clr_err;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     match;
  logic                     overflow;
  logic                     unstable;

  modport master (
    output count_in, trigger, match_val, match_en, clr_err, out_ready,
    input  out_data, out_valid, level, match, overflow, unstable
  );

  modport slave (
    input  count_in, trigger, match_val, match_en, clr_err, out_ready,
    output out_data, out_valid, level, match, overflow, unstable
  );
endinterface

// File: rtl/cpt_capture8.sv
// Resamples a rippling counter, captures a settled value per trigger rising edge into a
// small FIFO drained over valid/ready, and pulses on a programmable compare match.
module cpt_capture8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TMO   = 3
) (
  input logic           clk,
  input logic           reset,
  cpt_capture8_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic {IDLE, WAIT_STABLE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] s1, s2;
  logic             trig_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q;
  logic             overflow_q, unstable_q, hit_q, match_q;

  logic stable, rise, hit, push, forced, pop, full, do_push, dropped;

  // Two equal consecutive samples mean the ripple has settled.
  assign stable  = (s1 == s2);
  assign rise    = bus.trigger & ~trig_q;
  assign hit     = stable & (s2 == bus.match_val);
  assign pop     = (level_q != '0) & bus.out_ready;
  assign full    = (level_q == LW'(DEPTH));
  assign do_push = push & (~full | pop);
  assign dropped = push & full & ~pop;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    push    = 1'b0;
    forced  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = WAIT_STABLE;
          tmo_d   = '0;
        end
      end
      WAIT_STABLE: begin
        if (stable) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          push    = 1'b1;
          forced  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      trig_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      unstable_q <= 1'b0;
      hit_q      <= 1'b0;
      match_q    <= 1'b0;
      // NOTE: the storage is cleared too, so the empty-FIFO out_data reads zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1     <= bus.count_in;
      s2     <= s1;
      trig_q <= bus.trigger;
      hit_q  <= hit;
      match_q <= bus.match_en & hit & ~hit_q;

      if (do_push) begin
        mem[wr_ptr] <= s2;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({do_push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase

      // A set event in the same cycle as clr_err wins.
      if (dropped)          overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;
      if (forced)           unstable_q <= 1'b1;
      else if (bus.clr_err) unstable_q <= 1'b0;
    end
  end

  // When empty, the slot behind rd_ptr still holds the last entry that was drained.
  assign bus.out_data  = (level_q == '0) ? mem[rd_ptr - AW'(1)] : mem[rd_ptr];
  assign bus.out_valid = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.match     = match_q;
  assign bus.overflow  = overflow_q;
  assign bus.unstable  = unstable_q;
endmodule
